// File: rtl/demux_tdm_ser_if.sv
// Serial link bundle for the 4-channel TDM receive demux.
// master drives start_ul/en_ul/inf_ul; slave returns channel words and status.
interface demux_tdm_ser_if #(
  parameter int W = 4
);
  logic           start_ul;
  logic           en_ul;
  logic           inf_ul;
  logic [4*W-1:0] inf_izl;
  logic [1:0]     adr_izl;
  logic           busy;
  logic           frame_rdy;
  logic           par_err;

  modport master (
    output start_ul, en_ul, inf_ul,
    input  inf_izl, adr_izl, busy, frame_rdy, par_err
  );

  modport slave (
    input  start_ul, en_ul, inf_ul,
    output inf_izl, adr_izl, busy, frame_rdy, par_err
  );
endinterface

// File: rtl/demux_tdm_ser.sv
// 4-channel TDM serial receive demux: frames bits after a start strobe and
// steers each bit to channel adr_izl, LSB first, committing to inf_izl.
// Ports: clk, rst (sync, active-high), bus (demux_tdm_ser_if.slave):
//   start_ul/en_ul/inf_ul in; inf_izl, adr_izl, busy, frame_rdy, par_err out.
// Option: define PARITY_EN for a trailing even-parity bit and PAR state.
module demux_tdm_ser #(
  parameter int W = 4
) (
  input logic             clk,
  input logic             rst,
  demux_tdm_ser_if.slave  bus
);
  localparam int N  = 4 * W;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    PAR  = 2'd2
  } state_t;

  state_t         state_q;
  logic [N-1:0]   shadow_q;
  logic [N-1:0]   shadow_d;
  logic [N-1:0]   inf_q;
  logic [CW-1:0]  bit_q;
  logic [1:0]     adr_q;
  logic           busy_q;
  logic           rdy_q;
  logic [IW-1:0]  idx;
  logic           last_bit;

  assign idx = IW'(adr_q) * IW'(W) + IW'(bit_q);
  assign last_bit = (adr_q == 2'd3) && (bit_q == CW'(W - 1));

  always_comb begin
    shadow_d      = shadow_q;
    shadow_d[idx] = bus.inf_ul;
  end

`ifdef PARITY_EN
  logic perr_q;
  logic par_ok;

  // Even parity: data XOR parity bit must be zero.
  assign par_ok = ~(^shadow_q ^ bus.inf_ul);
  assign bus.par_err = perr_q;
`else
  assign bus.par_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      inf_q    <= '0;
      bit_q    <= '0;
      adr_q    <= '0;
      busy_q   <= 1'b0;
      rdy_q    <= 1'b0;
`ifdef PARITY_EN
      perr_q   <= 1'b0;
`endif
    end else begin
      rdy_q  <= 1'b0;
`ifdef PARITY_EN
      perr_q <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          if (bus.start_ul) begin
            state_q  <= RECV;
            busy_q   <= 1'b1;
            bit_q    <= '0;
            adr_q    <= '0;
            shadow_q <= '0;
          end
        end
        RECV: begin
          if (bus.start_ul) begin
            // Abort: restart the frame, keep inf_izl.
            bit_q    <= '0;
            adr_q    <= '0;
            shadow_q <= '0;
          end else if (bus.en_ul) begin
            shadow_q <= shadow_d;
            if (last_bit) begin
              bit_q <= '0;
`ifdef PARITY_EN
              state_q <= PAR;
`else
              state_q <= IDLE;
              inf_q   <= shadow_d;
              rdy_q   <= 1'b1;
              busy_q  <= 1'b0;
              adr_q   <= '0;
`endif
            end else if (bit_q == CW'(W - 1)) begin
              bit_q <= '0;
              adr_q <= adr_q + 2'd1;
            end else begin
              bit_q <= bit_q + CW'(1);
            end
          end
        end
`ifdef PARITY_EN
        PAR: begin
          if (bus.start_ul) begin
            state_q  <= RECV;
            bit_q    <= '0;
            adr_q    <= '0;
            shadow_q <= '0;
          end else if (bus.en_ul) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            adr_q   <= '0;
            if (par_ok) begin
              inf_q <= shadow_q;
              rdy_q <= 1'b1;
            end else begin
              perr_q <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          adr_q   <= '0;
          bit_q   <= '0;
        end
      endcase
    end
  end

  assign bus.inf_izl   = inf_q;
  assign bus.adr_izl   = adr_q;
  assign bus.busy      = busy_q;
  assign bus.frame_rdy = rdy_q;
endmodule

// File: tb/tb_demux_tdm_ser.sv
// Self-checking bench for demux_tdm_ser (W=4): frame-level model of the
// serial link plus directed frames with hand-computed channel words.
module tb_demux_tdm_ser;
  localparam int W = 4;
  localparam int N = 4 * W;
`ifdef PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic clk = 1'b0;
  logic rst;

  demux_tdm_ser_if #(.W(W)) bus ();

  demux_tdm_ser #(.W(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  int cyc      = 0;
  int rdy_cyc  = -1;
  int rdy_n    = 0;
  int perr_n   = 0;
  bit chk_en   = 1'b0;

  logic [N-1:0] m_inf;
  logic [1:0]   m_adr;
  logic         m_busy;
  logic         m_rdy;
  logic         m_perr;
  int           q[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  name, act, exp, cyc);
  endtask

  // Frame model: collect serial bits in arrival order; bit n of the
  // frame is bit n of the channel word vector.
  task automatic model(input logic r, input logic s, input logic e,
                       input logic d);
    int ones;
    m_rdy  = 1'b0;
    m_perr = 1'b0;
    if (r) begin
      m_inf  = '0;
      m_busy = 1'b0;
      m_adr  = 2'd0;
      q.delete();
    end else if (s) begin
      m_busy = 1'b1;
      m_adr  = 2'd0;
      q.delete();
    end else if (m_busy && e) begin
      q.push_back(int'(d));
      if (q.size() == N + P) begin
        ones = 0;
        foreach (q[i]) ones += q[i];
        if (P == 0 || ones % 2 == 0) begin
          for (int i = 0; i < N; i++) m_inf[i] = q[i][0];
          m_rdy = 1'b1;
        end else begin
          m_perr = 1'b1;
        end
        m_busy = 1'b0;
        m_adr  = 2'd0;
        q.delete();
      end else begin
        m_adr = (q.size() >= N) ? 2'd3 : 2'(q.size() / W);
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("inf_izl", 32'(bus.inf_izl), 32'(m_inf));
      check("adr_izl", 32'(bus.adr_izl), 32'(m_adr));
      check("busy", 32'(bus.busy), 32'(m_busy));
      check("frame_rdy", 32'(bus.frame_rdy), 32'(m_rdy));
      check("par_err", 32'(bus.par_err), 32'(m_perr));
      if (bus.frame_rdy === 1'b1) begin
        rdy_cyc = cyc;
        rdy_n++;
      end
      if (bus.par_err === 1'b1) perr_n++;
    end
  end

  task automatic step(input logic r, input logic s, input logic e,
                      input logic d);
    @(negedge clk);
    rst          = r;
    bus.start_ul = s;
    bus.en_ul    = e;
    bus.inf_ul   = d;
    @(posedge clk);
    cyc++;
    model(r, s, e, d);
    chk_en = 1'b1;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)));
  endtask

  task automatic send_bits(input logic [N-1:0] w, input int from,
                           input int to);
    for (int i = from; i < to; i++) step(1'b0, 1'b0, 1'b1, w[i]);
  endtask

  // Start strobe, N data bits (optional en_ul gaps), and parity if built.
  task automatic send_frame(input logic [N-1:0] w, input int g1at,
                            input int g1len, input int g2at, input int g2len,
                            input logic flip, output int c0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    c0 = cyc;
    for (int i = 0; i < N; i++) begin
      if (i == g1at)
        for (int k = 0; k < g1len; k++) step(1'b0, 1'b0, 1'b0, 1'b1);
      if (i == g2at)
        for (int k = 0; k < g2len; k++) step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1, w[i]);
    end
    if (P == 1) step(1'b0, 1'b0, 1'b1, (^w) ^ flip);
  endtask

  initial begin
    int c0;
    int n0;
    logic [N-1:0] a321;
    logic [N-1:0] f5f0c;
    a321  = 16'hA321;
    f5f0c = 16'h5F0C;
    m_inf = '0; m_adr = '0; m_busy = 1'b0; m_rdy = 1'b0; m_perr = 1'b0;
    rst = 1'b1;
    bus.start_ul = 1'b0;
    bus.en_ul    = 1'b0;
    bus.inf_ul   = 1'b0;

    // 1. reset
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check("rst inf", 32'(bus.inf_izl), 32'h0);
    check("rst busy", 32'(bus.busy), 32'h0);
    check("rst adr", 32'(bus.adr_izl), 32'h0);
    idle(3);

    // 2. contiguous frame A321
    n0 = rdy_n;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    c0 = cyc;
    send_bits(a321, 0, 5);
    check("t2 adr after 5", 32'(bus.adr_izl), 32'd1);
    send_bits(a321, 5, 9);
    check("t2 adr after 9", 32'(bus.adr_izl), 32'd2);
    send_bits(a321, 9, N);
    if (P == 1) step(1'b0, 1'b0, 1'b1, ^a321);
    idle(2);
    check("t2 inf", 32'(bus.inf_izl), 32'hA321);
    check("t2 model", 32'(m_inf), 32'hA321);
    check("t2 latency", 32'(rdy_cyc - c0), 32'(16 + P));
    check("t2 pulses", 32'(rdy_n - n0), 32'd1);

    // 3. en_ul gaps of 1 and 3 cycles
    n0 = rdy_n;
    send_frame(a321, 1, 1, 9, 3, 1'b0, c0);
    idle(2);
    check("t3 inf", 32'(bus.inf_izl), 32'hA321);
    check("t3 latency", 32'(rdy_cyc - c0), 32'(20 + P));
    check("t3 pulses", 32'(rdy_n - n0), 32'd1);

    // 4. abort after 6 bits, then 5F0C
    n0 = rdy_n;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    send_bits(f5f0c, 0, 6);
    check("t4 mid busy", 32'(bus.busy), 32'd1);
    send_frame(f5f0c, -1, 0, -1, 0, 1'b0, c0);
    idle(1);
    check("t4 inf", 32'(bus.inf_izl), 32'h5F0C);
    check("t4 pulses", 32'(rdy_n - n0), 32'd1);

    // back-to-back: start in the cycle after commit
    send_frame(a321, -1, 0, -1, 0, 1'b0, c0);
    send_frame(16'h0FF0, -1, 0, -1, 0, 1'b0, c0);
    idle(1);
    check("b2b inf", 32'(bus.inf_izl), 32'h0FF0);

    // 5. reset mid-frame after 9 bits
    step(1'b0, 1'b1, 1'b0, 1'b0);
    send_bits(16'h1234, 0, 9);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("t5 inf", 32'(bus.inf_izl), 32'h0);
    check("t5 busy", 32'(bus.busy), 32'h0);
    check("t5 adr", 32'(bus.adr_izl), 32'h0);
    send_frame(16'h1234, -1, 0, -1, 0, 1'b0, c0);
    idle(1);
    check("t5 inf after", 32'(bus.inf_izl), 32'h1234);

`ifdef PARITY_EN
    // 6. A321 has 6 ones: even parity bit 0 commits, 1 fails
    n0 = rdy_n;
    send_frame(16'hFFFF, -1, 0, -1, 0, 1'b0, c0);
    send_frame(a321, -1, 0, -1, 0, 1'b0, c0);
    idle(1);
    check("t6 good inf", 32'(bus.inf_izl), 32'hA321);
    check("t6 good pulses", 32'(rdy_n - n0), 32'd2);
    n0 = rdy_n;
    c0 = perr_n;
    send_frame(16'h5F0C, -1, 0, -1, 0, 1'b1, c0);
    idle(1);
    check("t6 bad inf", 32'(bus.inf_izl), 32'hA321);
    check("t6 bad pulses", 32'(rdy_n - n0), 32'd0);
    check("t6 perr", 32'(perr_n), 32'd1);
`endif

    idle(3);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
